// File: rtl/instruction_fetch_unit.sv
// RV32IM instruction-fetch stage: owns the PC, drives the instruction-memory handshake,
// and absorbs wait states, hazard stalls and EX redirects. Define IFU_PERF_CNT_EN for perf counters.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INC   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_read,
   output logic [31:0] imem_addr,
   input  logic        imem_busy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] pc_next_out,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic        fetch_stall
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] wait_count
`endif
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   localparam logic [31:0] INC = 32'(PC_INC);

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] hold_buf, hold_nxt;
   logic [31:0] redir, redir_nxt;
   logic [31:0] target;

   assign target      = branch_target & ~32'h3;
   assign pc_out      = pc;
   assign imem_addr   = pc;
   assign pc_next_out = pc + INC;

   // NOTE: every output and next-state value gets a default first so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      hold_nxt    = hold_buf;
      redir_nxt   = redir;
      imem_read   = 1'b0;
      instr_out   = 32'd0;
      instr_valid = 1'b0;
      fetch_stall = 1'b0;
      case (state)
         FETCH: begin
            imem_read = 1'b1;
            if (imem_busy) begin
               fetch_stall = 1'b1;
            end else begin
               instr_out   = imem_rdata;
               instr_valid = 1'b1;
            end
            // A busy redirect must let the in-flight request finish at its original address.
            if (branch_taken && imem_busy) begin
               redir_nxt = target;
               state_nxt = DRAIN;
            end else if (branch_taken) begin
               pc_nxt = target;
            end else if (imem_busy) begin
               pc_nxt = pc;
            end else if (stall) begin
               hold_nxt  = imem_rdata;
               state_nxt = HOLD;
            end else begin
               pc_nxt = pc + INC;
            end
         end
         HOLD: begin
            instr_out   = hold_buf;
            instr_valid = 1'b1;
            if (branch_taken) begin
               pc_nxt    = target;
               state_nxt = FETCH;
            end else if (!stall) begin
               pc_nxt    = pc + INC;
               state_nxt = FETCH;
            end
         end
         DRAIN: begin
            imem_read   = 1'b1;
            fetch_stall = 1'b1;
            if (branch_taken) redir_nxt = target;
            if (!imem_busy) begin
               pc_nxt    = branch_taken ? target : redir;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         hold_buf <= 32'd0;
         redir    <= 32'd0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         hold_buf <= hold_nxt;
         redir    <= redir_nxt;
      end
   end

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= 32'd0;
         wait_count  <= 32'd0;
      end else begin
         if (state == FETCH && !imem_busy) fetch_count <= fetch_count + 32'd1;
         if (fetch_stall)                  wait_count  <= wait_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a directed table pushes expected presentations,
// a negedge monitor pops and compares them against every valid instruction the DUT presents.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic        imem_busy = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out, pc_next_out, instr_out;
   logic        instr_valid, fetch_stall;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_count, wait_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Memory returns a recognisable word derived from the address.
   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   instruction_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_read    (imem_read),
      .imem_addr    (imem_addr),
      .imem_busy    (imem_busy),
      .imem_rdata   (imem_rdata),
      .pc_out       (pc_out),
      .pc_next_out  (pc_next_out),
      .instr_out    (instr_out),
      .instr_valid  (instr_valid),
      .fetch_stall  (fetch_stall)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_count  (fetch_count),
      .wait_count   (wait_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        rst, busy, stl, br;
      logic [31:0] tgt;
      logic        ev;
      logic [31:0] epc;
      logic        erd, efs;
   } vec_t;

   vec_t vecs[30] = '{
      '{0,0,0,0,32'h0,        1,32'h0,        1,0},  // 0  free run after reset
      '{0,0,0,0,32'h0,        1,32'h4,        1,0},  // 1
      '{0,1,0,0,32'h0,        0,32'h8,        1,1},  // 2  busy x3 at 8
      '{0,1,0,0,32'h0,        0,32'h8,        1,1},  // 3
      '{0,1,0,0,32'h0,        0,32'h8,        1,1},  // 4
      '{0,0,0,0,32'h0,        1,32'h8,        1,0},  // 5  word for 8
      '{0,0,0,0,32'h0,        1,32'hC,        1,0},  // 6
      '{0,0,1,0,32'h0,        1,32'h10,       1,0},  // 7  stall at 16 -> HOLD
      '{0,0,1,0,32'h0,        1,32'h10,       0,0},  // 8  HOLD
      '{0,0,0,0,32'h0,        1,32'h10,       0,0},  // 9  HOLD release
      '{0,0,0,0,32'h0,        1,32'h14,       1,0},  // 10
      '{0,1,0,1,32'h100,      0,32'h18,       1,1},  // 11 busy redirect -> DRAIN
      '{0,1,0,0,32'h0,        0,32'h18,       1,1},  // 12 DRAIN
      '{0,0,0,0,32'h0,        0,32'h18,       1,1},  // 13 busy drops
      '{0,0,0,0,32'h0,        1,32'h100,      1,0},  // 14
      '{0,1,0,1,32'h300,      0,32'h104,      1,1},  // 15 DRAIN to 0x300
      '{0,1,0,1,32'h200,      0,32'h104,      1,1},  // 16 newer target 0x200
      '{0,1,1,0,32'h0,        0,32'h104,      1,1},  // 17 stall ignored in DRAIN
      '{0,0,0,0,32'h0,        0,32'h104,      1,1},  // 18
      '{0,0,0,1,32'h103,      1,32'h200,      1,0},  // 19 unaligned target
      '{0,0,0,0,32'h0,        1,32'h100,      1,0},  // 20
      '{0,0,1,1,32'h40,       1,32'h104,      1,0},  // 21 stall+branch: branch wins
      '{0,0,1,0,32'h0,        1,32'h40,       1,0},  // 22 -> HOLD
      '{0,0,1,1,32'h80,       1,32'h40,       0,0},  // 23 branch out of HOLD
      '{0,0,0,0,32'h0,        1,32'h80,       1,0},  // 24
      '{0,1,0,1,32'h500,      0,32'h84,       1,1},  // 25 -> DRAIN
      '{1,1,0,0,32'h0,        0,32'h0,        0,0},  // 26 reset mid-DRAIN
      '{0,0,0,1,32'hFFFF_FFFC,1,32'h0,        1,0},  // 27 back at RESET_PC
      '{0,0,0,0,32'h0,        1,32'hFFFF_FFFC,1,0},  // 28 wrap
      '{0,0,0,0,32'h0,        1,32'h0,        1,0}   // 29
   };

   always @(negedge clk) begin
      if (!reset && instr_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", pc_out, 32'hDEAD_BEEF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_pc", pc_out, e.pc);
            check("sb_instr", instr_out, e.instr);
            check("sb_pc_next", pc_next_out, e.pc + 32'd4);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         reset         = vecs[i].rst;
         imem_busy     = vecs[i].busy;
         stall         = vecs[i].stl;
         branch_taken  = vecs[i].br;
         branch_target = vecs[i].tgt;
         if (!vecs[i].rst && vecs[i].ev)
            sb.push_back('{vecs[i].epc, vecs[i].epc ^ 32'hA5A5_0000});
         @(negedge clk);
         if (!vecs[i].rst) begin
            check($sformatf("addr_%0d", i), imem_addr, vecs[i].epc);
            check($sformatf("read_%0d", i), {31'd0, imem_read}, {31'd0, vecs[i].erd});
            check($sformatf("fstall_%0d", i), {31'd0, fetch_stall}, {31'd0, vecs[i].efs});
            check($sformatf("valid_%0d", i), {31'd0, instr_valid}, {31'd0, vecs[i].ev});
            if (!vecs[i].ev) check($sformatf("bubble_%0d", i), instr_out, 32'd0);
         end
`ifdef IFU_PERF_CNT_EN
         if (i == 5) begin
            check("wait_count", wait_count, 32'd3);
            check("fetch_count", fetch_count, 32'd2);
         end
         if (i == 27) begin
            check("wait_count_rst", wait_count, 32'd0);
            check("fetch_count_rst", fetch_count, 32'd0);
         end
`endif
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      branch_taken = 1'b0;
      @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
